// File: rtl/nor_seq_pkg.sv
// Shared opcode, state and step-count definitions for the NOR-sequenced scheduler.
package nor_seq_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        DONE = 3'd4
    } state_e;

    // Number of passes through the shared NOR unit an opcode needs.
    function automatic logic [1:0] op_steps(input logic [1:0] op);
        case (op)
            OP_OR:   return 2'd2;
            OP_AND:  return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/nor_unit.sv
// The single shared WIDTH-bit NOR gate bank; purely combinational.
module nor_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x0_i,
    input  logic [WIDTH-1:0] x1_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = ~(x0_i | x1_i);

endmodule

// File: rtl/nor_op_arbiter.sv
// Round-robin scheduler running NOT/OR/AND/NOR requests as NOR step sequences on one nor_unit.
// Optional NOR_OP_COUNT_EN adds an 8-bit wrapping count of result handshakes (done_count).
module nor_op_arbiter
    import nor_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_src,
    output logic             busy
`ifdef NOR_OP_COUNT_EN
    ,
    output logic [7:0]       done_count
`endif
);

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, t1_q, t2_q, res_data_q;
    logic             src_q, res_src_q, res_valid_q, ptr_q;
    logic             gnt0, gnt1, last_step;
    logic [1:0]       cur_step;
    logic [WIDTH-1:0] x0, x1, y;

    // Pointer only breaks ties; a lone requester always wins.
    assign gnt0 = req0_valid && (!req1_valid || !ptr_q);
    assign gnt1 = req1_valid && (!req0_valid ||  ptr_q);

    assign req0_ready = reset_n && (state_q == IDLE) && gnt0;
    assign req1_ready = reset_n && (state_q == IDLE) && gnt1;

    always_comb begin
        cur_step = 2'd0;
        case (state_q)
            S1:      cur_step = 2'd1;
            S2:      cur_step = 2'd2;
            S3:      cur_step = 2'd3;
            default: cur_step = 2'd0;
        endcase
    end

    assign last_step = (cur_step == op_steps(op_q));

    always_comb begin
        x0 = '0;
        x1 = '0;
        case (state_q)
            S1: begin
                x0 = a_q;
                x1 = (op_q == OP_OR || op_q == OP_NOR) ? b_q : '0;
            end
            S2:      x0 = (op_q == OP_AND) ? b_q : t1_q;
            S3: begin
                x0 = t1_q;
                x1 = t2_q;
            end
            default: ;
        endcase
    end

    nor_unit #(.WIDTH(WIDTH)) u_nor (
        .x0_i (x0),
        .x1_i (x1),
        .y_o  (y)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0_valid || req1_valid) state_d = S1;
            S1:      state_d = last_step ? DONE : S2;
            S2:      state_d = last_step ? DONE : S3;
            S3:      state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= OP_NOT;
            a_q         <= '0;
            b_q         <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            src_q       <= 1'b0;
            res_data_q  <= '0;
            res_src_q   <= 1'b0;
            res_valid_q <= 1'b0;
            ptr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req0_valid || req1_valid) begin
                    src_q <= gnt1;
                    op_q  <= gnt1 ? req1_op : req0_op;
                    a_q   <= gnt1 ? req1_a  : req0_a;
                    b_q   <= gnt1 ? req1_b  : req0_b;
                end
                S1, S2, S3: begin
                    if (last_step) begin
                        res_data_q  <= y;
                        res_src_q   <= src_q;
                        res_valid_q <= 1'b1;
                    end else if (state_q == S1) begin
                        t1_q <= y;
                    end else begin
                        t2_q <= y;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    ptr_q       <= ~res_src_q;
                end
                default: ;
            endcase
        end
    end

`ifdef NOR_OP_COUNT_EN
    logic [7:0] done_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done_count_q <= 8'd0;
        else if (state_q == DONE && res_ready)
            done_count_q <= done_count_q + 8'd1;
    end

    assign done_count = done_count_q;
`endif

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_src   = res_src_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nor_op_arbiter.sv
// Randomized self-checking bench for nor_op_arbiter against a boolean reference model.
module tb_nor_op_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_src, busy;
    logic [W-1:0] res_data;
`ifdef NOR_OP_COUNT_EN
    logic [7:0]   done_count;
`endif

    int checks = 0;
    int errors = 0;

    nor_op_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_src    (res_src),
        .busy       (busy)
`ifdef NOR_OP_COUNT_EN
        ,
        .done_count (done_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference: boolean meaning of each opcode and its cycle cost in NOR passes.
    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a | b;
            2'b10:   return a & b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op);
        case (op)
            2'b01:   return 2;
            2'b10:   return 3;
            default: return 1;
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
    endtask

    // Drives one request to completion; returns observations only.
    task automatic run_txn(input bit s, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, output int lat, output logic [W-1:0] d, output logic ds, output bit tmo);
        int n;
        tmo = 0; lat = 0; n = 0;
        if (s) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else   begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        #1;
        while (!(s ? req1_ready : req0_ready) && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) tmo = 1;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        // Scramble inputs after accept; they must not matter.
        req0_op = 2'($urandom); req1_op = 2'($urandom);
        req0_a = W'($urandom); req0_b = W'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
        while (!res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (lat >= 20) tmo = 1;
        d = res_data; ds = res_src;
        repeat (hold) begin @(posedge clk); #1; end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", res_valid); end
        checks++; if (res_data !== '0)    begin errors++; $display("FAIL rst_data: got %b exp 0000", res_data); end
        checks++; if (res_src !== 1'b0)   begin errors++; $display("FAIL rst_src: got %b exp 0", res_src); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", {req0_ready, req1_ready}); end
        idle_inputs();
        reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_ops();
        logic [1:0] ops [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic [W-1:0] exp_d [4] = '{4'b1000, 4'b1110, 4'b0011, 4'b0001};
        int exp_l [4] = '{3, 2, 1, 1};
        int lat; logic [W-1:0] d; logic ds; bit tmo; bit s;
        for (int i = 0; i < 4; i++) begin
            s = (i != 0);
            run_txn(s, ops[i], 4'b1100, 4'b1010, 0, lat, d, ds, tmo);
            checks++; if (tmo)          begin errors++; $display("FAIL op%0d_timeout: handshake timed out", i); end
            checks++; if (d !== exp_d[i]) begin errors++; $display("FAIL op%0d_data: got %b exp %b", i, d, exp_d[i]); end
            checks++; if (lat != exp_l[i]) begin errors++; $display("FAIL op%0d_lat: got %0d exp %0d", i, lat, exp_l[i]); end
            checks++; if (ds !== s)     begin errors++; $display("FAIL op%0d_src: got %b exp %b", i, ds, s); end
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] d, a, b; logic ds; bit tmo; bit s; logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom); op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            run_txn(s, op, a, b, $urandom_range(0, 3), lat, d, ds, tmo);
            checks++;
            if (tmo || d !== ref_op(op, a, b) || lat != ref_lat(op) || ds !== s) begin
                errors++;
                $display("FAIL rand%0d: op=%b a=%b b=%b got d=%b lat=%0d src=%b tmo=%0d exp d=%b lat=%0d src=%b",
                         i, op, a, b, d, lat, ds, tmo, ref_op(op, a, b), ref_lat(op), s);
            end
        end
    endtask

    task automatic test_arbitration();
        bit exp_g, g, pend;
        int grants, results, n;
        apply_reset();
        req0_valid = 1; req0_op = 2'b11; req0_a = 4'b0000; req0_b = 4'b0000;
        req1_valid = 1; req1_op = 2'b11; req1_a = 4'b1111; req1_b = 4'b1111;
        res_ready = 1;
        #1;
        exp_g = 0; pend = 0; grants = 0; results = 0; n = 0;
        while (results < 4 && n < 60) begin
            checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL arb_both_ready: got 11 exp at most one"); end
            if (res_valid) begin
                checks++;
                if (res_src !== pend || res_data !== (pend ? 4'b0000 : 4'b1111)) begin
                    errors++; $display("FAIL arb_result%0d: got src=%b data=%b exp src=%b data=%b",
                                       results, res_src, res_data, pend, pend ? 4'b0000 : 4'b1111);
                end
                results++;
            end
            if (grants < 4 && (req0_ready || req1_ready)) begin
                g = req1_ready;
                checks++; if (g !== exp_g) begin errors++; $display("FAIL arb_grant%0d: got %b exp %b", grants, g, exp_g); end
                pend = g; exp_g = ~g; grants++;
            end
            @(posedge clk); #1; n++;
        end
        checks++; if (results < 4) begin errors++; $display("FAIL arb_timeout: got %0d results exp 4", results); end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_d;
        int n;
        apply_reset();
        exp_d = ref_op(2'b01, 4'b0101, 4'b0010);
        req0_valid = 1; req0_op = 2'b01; req0_a = 4'b0101; req0_b = 4'b0010;
        #1;
        @(posedge clk); #1;
        req0_valid = 0;
        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        req1_valid = 1; req1_op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_d || res_src !== 1'b0 || busy !== 1'b1 ||
                {req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%b src=%b busy=%b rdy=%b exp v=1 d=%b src=0 busy=1 rdy=00",
                         i, res_valid, res_data, res_src, busy, {req0_ready, req1_ready}, exp_d);
            end
            @(posedge clk); #1;
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b exp v=0 busy=0", res_valid, busy); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_next_ready: got %b exp 1", req1_ready); end
        req1_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        req0_valid = 1; req0_op = 2'b10; req0_a = 4'b1100; req0_b = 4'b1010;
        #1;
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b exp 1", busy); end
        req0_valid = 1; req1_valid = 1; req1_op = 2'b10; req1_a = 4'b0110; req1_b = 4'b0011;
        reset_n = 0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL mid_reset: got v=%b busy=%b rdy=%b exp v=0 busy=0 rdy=00",
                               res_valid, busy, {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        reset_n = 1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_grant: got %b exp 10", {req0_ready, req1_ready}); end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (res_data !== 4'b1000 || res_src !== 1'b0 || n != 3) begin
            errors++; $display("FAIL mid_result: got d=%b src=%b lat=%0d exp d=1000 src=0 lat=3", res_data, res_src, n);
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

`ifdef NOR_OP_COUNT_EN
    task automatic test_count();
        int lat; logic [W-1:0] d; logic ds; bit tmo;
        apply_reset();
        checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL cnt_start: got %0d exp 0", done_count); end
        for (int i = 0; i < 257; i++)
            run_txn(1'($urandom), 2'($urandom), W'($urandom), W'($urandom), 0, lat, d, ds, tmo);
        checks++; if (done_count !== 8'd1) begin errors++; $display("FAIL cnt_wrap: got %0d exp 1", done_count); end
        reset_n = 0;
        #1;
        checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL cnt_reset: got %0d exp 0", done_count); end
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_ops();
        test_random();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
`ifdef NOR_OP_COUNT_EN
        test_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nor_op_arbiter.md
Name: nor_op_arbiter

Overview:
- Shares one WIDTH-bit NOR unit between two requesters.
- Each request (NOT, OR, AND or NOR on two operands) is run as a short sequence of NOR steps through that single unit, with intermediate values kept in registers.
- Round-robin arbitration on the request side; valid/ready handshake on the result side.
- Sits between lab-level requesters and the NOR-only logic datapath as its scheduler.

Parameters:
WIDTH, 4, operand/result bit width (>=1)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_op  input  2  opcode, requester 0
req0_a  input  WIDTH  operand A, requester 0
req0_b  input  WIDTH  operand B, requester 0
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, requester 1
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  result
res_src  output  1  index of the requester that owns the result
busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state IDLE, res_valid 0, res_data 0, res_src 0, busy 0, priority pointer 0, temporaries 0; req*_ready forced 0 while reset_n is low.
- Opcodes and NOR steps (each step is one cycle through the shared unit):
  - 00 NOT: 1 step, nor(A,0).
  - 01 OR: 2 steps, t1=nor(A,B), then out=nor(t1,0).
  - 10 AND: 3 steps, t1=nor(A,0), t2=nor(B,0), then out=nor(t1,t2).
  - 11 NOR: 1 step, nor(A,B).
- States: IDLE -> S1 -> (S2 -> (S3)) -> DONE -> IDLE.
- Arbitration (IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - reqN_ready = (state==IDLE) && granted(N), combinational, so at most one ready is high.
- Accept edge: op, A, B and src are latched; state goes to S1.
- Requester inputs are ignored outside the accept edge, so post-accept input changes have no effect.
- Latency: res_valid rises on the Kth edge after the accept edge. K=1 for NOT/NOR, 2 for OR, 3 for AND.
- res_data is registered and written on the final step edge.
- DONE:
  - res_valid, res_data and res_src hold stable until res_ready is high.
  - On the handshake edge: state goes to IDLE, res_valid to 0, priority pointer to ~res_src.
- Throughput: no overlap. The earliest next accept is the edge after the result handshake, so a new request sees ready 1 cycle after the handshake.
- res_ready high outside DONE has no effect.
- reset_n low mid-transaction: the transaction is discarded immediately (asynchronous), no result is produced, and all outputs take their reset values.
- Unknown or X opcodes are not expected; all 4 encodings are defined.

Optional Feature:
- Macro: NOR_OP_COUNT_EN.
- Defined: adds output done_count[7:0], reset 0, incremented on each result handshake, wraps 255 -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package nor_seq_pkg holds:
  - opcode constants OP_NOT=2'b00, OP_OR=2'b01, OP_AND=2'b10, OP_NOR=2'b11;
  - state encodings IDLE, S1, S2, S3, DONE;
  - step counts per opcode.
- One sub-module, nor_unit: combinational, WIDTH-parameterised, y = ~(x0 | x1).
- nor_unit is instantiated exactly once. The operand muxing (A/B/t1/t2/0) per state lives in nor_op_arbiter.

Test Plan:
- WIDTH=4, req0 AND a=1100 b=1010, res_ready=1 -> res_data=1000, res_src=0, res_valid on 3rd edge after accept.
- Single-step and OR ops, same operands from req1:
  - OR -> 1110, res_valid on 2nd edge after accept;
  - NOT -> 0011, on 1st edge;
  - NOR -> 0001, on 1st edge;
  - res_src=1 in every case.
- Arbitration after reset: both valid held high, op NOR, req0 a=0000 b=0000, req1 a=1111 b=1111.
  - Grant order: req0, req1, req0, req1.
  - res_data alternates 1111, 0000.
  - Never both ready in one cycle.
- Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid=1, res_data and res_src stable, busy=1, both ready=0.
  - Handshake on cycle 6 -> IDLE.
- Reset mid-AND (state S2): reset_n low -> res_valid=0, busy=0, ready=0 immediately.
  - After release, both valid -> req0 granted (pointer 0) and completes correctly.
- NOR_OP_COUNT_EN defined: 257 completed transactions -> done_count=1.
  - reset_n pulse -> done_count=0.
